// File: rtl/f_le_server.sv
// f_le_server: pipelined IEEE-754 "a <= b" compare responder.
// Stage S1 registers operand classification, stage S2 registers the final
// result and drives the resp_* outputs straight from flops.
// Optional build macro F_LE_STICKY_ERR_EN adds err_clr / err_sticky.
module f_le_server #(
    parameter int unsigned FLEN  = 64,
    parameter int unsigned EXP_W = 11,
    parameter int unsigned TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [FLEN-1:0]  req_a,
    input  logic [FLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_res,
    output logic             resp_err,
    output logic [TAG_W-1:0] resp_tag
`ifdef F_LE_STICKY_ERR_EN
    ,
    input  logic             err_clr,
    output logic             err_sticky
`endif
);

    localparam int unsigned MANT_W = FLEN - 1 - EXP_W;

    // Operand fields
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [MANT_W-1:0] man_a, man_b;
    logic              a_nan, b_nan, both_zero, mag_le, mag_ge;

    // S1 state
    logic              s1_valid;
    logic              s1_a_nan, s1_b_nan;
    logic              s1_sign_a, s1_sign_b;
    logic              s1_both_zero;
    logic              s1_mag_le, s1_mag_ge;
    logic [TAG_W-1:0]  s1_tag;

    // Flow control and S2 next-state
    logic              s1_en, s2_en;
    logic              s2_res_d, s2_err_d;

    assign exp_a = req_a[FLEN-2 -: EXP_W];
    assign exp_b = req_b[FLEN-2 -: EXP_W];
    assign man_a = req_a[MANT_W-1:0];
    assign man_b = req_b[MANT_W-1:0];

    assign a_nan     = (&exp_a) && (|man_a);
    assign b_nan     = (&exp_b) && (|man_b);
    assign both_zero = ~|req_a[FLEN-2:0] && ~|req_b[FLEN-2:0];
    // {exp,mant} ordered as an unsigned integer matches magnitude order
    assign mag_le    = req_a[FLEN-2:0] <= req_b[FLEN-2:0];
    assign mag_ge    = req_a[FLEN-2:0] >= req_b[FLEN-2:0];

    // An empty stage always accepts, so bubbles collapse under backpressure
    assign s2_en     = !resp_valid || resp_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign req_ready = s1_en;

    // S1: register the classification of an accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_a_nan     <= 1'b0;
            s1_b_nan     <= 1'b0;
            s1_sign_a    <= 1'b0;
            s1_sign_b    <= 1'b0;
            s1_both_zero <= 1'b0;
            s1_mag_le    <= 1'b0;
            s1_mag_ge    <= 1'b0;
            s1_tag       <= '0;
        end else if (s1_en) begin
            s1_valid <= req_valid;
            if (req_valid) begin
                s1_a_nan     <= a_nan;
                s1_b_nan     <= b_nan;
                s1_sign_a    <= req_a[FLEN-1];
                s1_sign_b    <= req_b[FLEN-1];
                s1_both_zero <= both_zero;
                s1_mag_le    <= mag_le;
                s1_mag_ge    <= mag_ge;
                s1_tag       <= req_tag;
            end
        end
    end

    // Result rules in priority order: NaN, signed zeros, sign, magnitude
    always_comb begin
        s2_res_d = 1'b0;
        s2_err_d = 1'b0;
        if (s1_a_nan || s1_b_nan) begin
            s2_err_d = 1'b1;
        end else if (s1_both_zero) begin
            s2_res_d = 1'b1;
        end else if (s1_sign_a != s1_sign_b) begin
            s2_res_d = s1_sign_a;
        end else if (!s1_sign_a) begin
            s2_res_d = s1_mag_le;
        end else begin
            s2_res_d = s1_mag_ge;
        end
    end

    // S2: output register, holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_res   <= 1'b0;
            resp_err   <= 1'b0;
            resp_tag   <= '0;
        end else if (s2_en) begin
            resp_valid <= s1_valid;
            if (s1_valid) begin
                resp_res <= s2_res_d;
                resp_err <= s2_err_d;
                resp_tag <= s1_tag;
            end
        end
    end

`ifdef F_LE_STICKY_ERR_EN
    // Sticky NaN flag: set on an err response transfer, set beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (resp_valid && resp_ready && resp_err) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule
